// File: rtl/tic_tac_toe_pkg.sv
// Shared definitions for the tic-tac-toe computer opponent: cell codes,
// line and pick-order tables, FSM state encoding and a cell extraction helper.
package tic_tac_toe_pkg;

    localparam logic [1:0] CELL_EMPTY    = 2'b00;
    localparam logic [1:0] CELL_PLAYER   = 2'b01;
    localparam logic [1:0] CELL_COMPUTER = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WIN   = 3'd1;
    localparam logic [2:0] ST_BLOCK = 3'd2;
    localparam logic [2:0] ST_PICK  = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    localparam logic [3:0] LINE_CELLS [0:7][0:2] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Centre first, then corners, then edges.
    localparam logic [3:0] PICK_ORDER [0:8] = '{
        4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
    };

    function automatic logic [1:0] cell_at(input logic [17:0] snap, input logic [3:0] pos);
        return snap[{pos, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/tic_tac_toe_computer_player_if.sv
// Connection between the game core (master) and the computer player (slave).
interface tic_tac_toe_computer_player_if;

    // request is a level held by the master and sampled only while the player
    // is idle; pc is a one-way valid pulse with no ready, so the game must take
    // computer_position on every cycle pc is high. no_move never coincides with pc.
    logic        request;
    logic [17:0] board;
    logic        pc;
    logic [3:0]  computer_position;
    logic        busy;
    logic        no_move;
    logic [2:0]  fsm_state;

    modport master (
        output request, board,
        input  pc, computer_position, busy, no_move, fsm_state
    );

    modport slave (
        input  request, board,
        output pc, computer_position, busy, no_move, fsm_state
    );

endinterface

// File: rtl/tic_tac_toe_line_eval.sv
// Checks one three-cell line for two cells of a given mark plus one empty cell.
module tic_tac_toe_line_eval
    import tic_tac_toe_pkg::*;
(
    input  logic [1:0] cell_a,
    input  logic [1:0] cell_b,
    input  logic [1:0] cell_c,
    input  logic [1:0] mark,
    output logic       hit,
    output logic [1:0] empty_slot
);

    always_comb begin
        hit        = 1'b0;
        empty_slot = 2'd0;
        if (cell_a == mark && cell_b == mark && cell_c == CELL_EMPTY) begin
            hit        = 1'b1;
            empty_slot = 2'd2;
        end else if (cell_a == mark && cell_c == mark && cell_b == CELL_EMPTY) begin
            hit        = 1'b1;
            empty_slot = 2'd1;
        end else if (cell_b == mark && cell_c == mark && cell_a == CELL_EMPTY) begin
            hit        = 1'b1;
            empty_slot = 2'd0;
        end
    end

endmodule

// File: rtl/tic_tac_toe_computer_player.sv
// Computer opponent: snapshots the board, scans for a win, then a block,
// then falls back to a fixed preference order, and emits the move as a pc pulse.
module tic_tac_toe_computer_player
    import tic_tac_toe_pkg::*;
#(
    parameter int unsigned PC_PULSE_CYCLES = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    tic_tac_toe_computer_player_if.slave  bus
);

    localparam int CW = (PC_PULSE_CYCLES > 1) ? $clog2(PC_PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PC_PULSE_CYCLES - 1);

    logic [2:0]    state;
    logic [2:0]    idx;
    logic [17:0]   snapshot;
    logic [CW-1:0] pulse_cnt;
    logic          pc_q;
    logic          no_move_q;
    logic [3:0]    position_q;

    logic [1:0]    mark;
    logic          line_hit;
    logic [1:0]    empty_slot;
    logic [3:0]    hit_pos;
    logic          pick_found;
    logic [3:0]    pick_pos;

    // One evaluator serves both scans; only the mark differs.
    assign mark = (state == ST_BLOCK) ? CELL_PLAYER : CELL_COMPUTER;

    tic_tac_toe_line_eval u_line_eval (
        .cell_a     (cell_at(snapshot, LINE_CELLS[idx][0])),
        .cell_b     (cell_at(snapshot, LINE_CELLS[idx][1])),
        .cell_c     (cell_at(snapshot, LINE_CELLS[idx][2])),
        .mark       (mark),
        .hit        (line_hit),
        .empty_slot (empty_slot)
    );

    assign hit_pos = LINE_CELLS[idx][empty_slot];

    always_comb begin
        pick_found = 1'b0;
        pick_pos   = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (!pick_found && cell_at(snapshot, PICK_ORDER[i]) == CELL_EMPTY) begin
                pick_found = 1'b1;
                pick_pos   = PICK_ORDER[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            snapshot   <= 18'd0;
            pulse_cnt  <= '0;
            pc_q       <= 1'b0;
            no_move_q  <= 1'b0;
            position_q <= 4'd0;
        end else begin
            no_move_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.request) begin
                        snapshot <= bus.board;
                        idx      <= 3'd0;
                        state    <= ST_WIN;
                    end
                end
                ST_WIN, ST_BLOCK: begin
                    if (line_hit) begin
                        position_q <= hit_pos;
                        pc_q       <= 1'b1;
                        pulse_cnt  <= '0;
                        state      <= ST_OUT;
                    end else if (idx == 3'd7) begin
                        idx   <= 3'd0;
                        state <= (state == ST_WIN) ? ST_BLOCK : ST_PICK;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_PICK: begin
                    if (pick_found) begin
                        position_q <= pick_pos;
                        pc_q       <= 1'b1;
                        pulse_cnt  <= '0;
                        state      <= ST_OUT;
                    end else begin
                        no_move_q <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        pc_q  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                default: begin
                    pc_q  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pc                = pc_q;
    assign bus.no_move           = no_move_q;
    assign bus.computer_position = position_q;
    assign bus.busy              = (state != ST_IDLE);
    assign bus.fsm_state         = state;

endmodule

// File: tb/tb_tic_tac_toe_computer_player.sv
// Directed and randomized moves against a rule-level model, on two players
// sharing stimulus: one with a 1-cycle pc pulse and one with a 3-cycle pulse.
module tb_tic_tac_toe_computer_player;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic [17:0] brd   = 18'd0;
    int          total = 0;
    int          bad   = 0;
    int          last_pos = 0;

    tic_tac_toe_computer_player_if bus ();
    tic_tac_toe_computer_player_if bus3 ();

    assign bus.request  = req;
    assign bus.board    = brd;
    assign bus3.request = req;
    assign bus3.board   = brd;

    tic_tac_toe_computer_player dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    tic_tac_toe_computer_player #(.PC_PULSE_CYCLES(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3.slave)
    );

    always #5 clock = ~clock;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int order [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Win search on every line first, then block search, then preference order.
    function automatic void model(input logic [17:0] b, output int lat, output int pos, output bit none);
        int c;
        int cnt;
        int e;
        lat  = 17;
        pos  = 0;
        none = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 8; k++) begin
                cnt = 0;
                e   = -1;
                for (int j = 0; j < 3; j++) begin
                    c = int'(b[2*lines[k][j] +: 2]);
                    if (c == (pass == 0 ? 2 : 1)) cnt++;
                    else if (c == 0) e = lines[k][j];
                end
                if (none && cnt == 2 && e >= 0) begin
                    lat  = pass * 8 + k + 1;
                    pos  = e;
                    none = 1'b0;
                end
            end
            if (!none) return;
        end
        for (int i = 0; i < 9; i++) begin
            if (none && b[2*order[i] +: 2] == 2'b00) begin
                pos  = order[i];
                none = 1'b0;
            end
        end
    endfunction

    task automatic run_move(input string tag, input logic [17:0] b, input bit repulse, input bit scramble);
        int  exp_lat;
        int  exp_pos;
        bit  none;
        int  n_hit;
        int  w1;
        int  w3;
        int  nm;
        int  overlap;
        int  moved;
        model(b, exp_lat, exp_pos, none);
        if (none) exp_pos = last_pos;
        @(negedge clock);
        brd = b;
        req = 1'b1;
        @(posedge clock);
        #1;
        check({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
        req = 1'b0;
        if (scramble) brd = 18'($urandom);
        n_hit = 0;
        for (int n = 1; n <= 30 && n_hit == 0; n++) begin
            @(posedge clock);
            #1;
            if (repulse && n == 2) req = 1'b1;
            if (repulse && n == 3) req = 1'b0;
            if (bus.pc || bus.no_move) n_hit = n;
        end
        check({tag, "_latency"}, n_hit, exp_lat);
        check({tag, "_pc"}, {31'd0, bus.pc}, {31'd0, !none});
        check({tag, "_no_move"}, {31'd0, bus.no_move}, {31'd0, none});
        check({tag, "_pos"}, {28'd0, bus.computer_position}, exp_pos);
        check({tag, "_pc3"}, {31'd0, bus3.pc}, {31'd0, !none});
        check({tag, "_pos3"}, {28'd0, bus3.computer_position}, exp_pos);
        w1 = int'(bus.pc);
        w3 = int'(bus3.pc);
        nm = int'(bus.no_move);
        overlap = 0;
        moved = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            w1 += int'(bus.pc);
            w3 += int'(bus3.pc);
            nm += int'(bus.no_move);
            if (bus.pc && bus.no_move) overlap++;
            if (bus.computer_position != 4'(exp_pos)) moved++;
            if (bus3.computer_position != 4'(exp_pos)) moved++;
        end
        check({tag, "_pc_width"}, w1, none ? 0 : 1);
        check({tag, "_pc3_width"}, w3, none ? 0 : 3);
        check({tag, "_no_move_width"}, nm, none ? 1 : 0);
        check({tag, "_overlap"}, overlap, 0);
        check({tag, "_pos_stable"}, moved, 0);
        check({tag, "_busy_end"}, {30'd0, bus.busy, bus3.busy}, 32'd0);
        last_pos = exp_pos;
    endtask

    initial begin
        logic [17:0] rb;
        int          v;

        repeat (2) @(posedge clock);
        #1;
        check("reset_pc", {31'd0, bus.pc}, 32'd0);
        check("reset_pos", {28'd0, bus.computer_position}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_no_move", {31'd0, bus.no_move}, 32'd0);
        reset = 1'b0;

        run_move("win", {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10}, 1'b0, 1'b1);
        run_move("block", {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01}, 1'b0, 1'b1);
        run_move("empty", 18'd0, 1'b0, 1'b0);
        run_move("centre_taken", {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00}, 1'b0, 1'b0);
        run_move("draw", {2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10}, 1'b0, 1'b0);

        // Reset during the win scan.
        @(negedge clock);
        brd = 18'd0;
        req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset_busy", {30'd0, bus.busy, bus3.busy}, 32'd0);
        check("midreset_pc", {30'd0, bus.pc, bus3.pc}, 32'd0);
        check("midreset_pos", {24'd0, bus.computer_position, bus3.computer_position}, 32'd0);
        check("midreset_no_move", {31'd0, bus.no_move}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        last_pos = 0;

        run_move("repulse", {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01}, 1'b1, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int c = 0; c < 9; c++) begin
                v = int'($urandom_range(0, 9));
                rb[2*c +: 2] = (v < 4) ? 2'b00 : (v < 6) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
            end
            run_move($sformatf("rand%0d", t), rb, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
